fifo_bypass_cfg: RTL and testbench
==================================

FIFO_BYPASS_CFG -- requirements
Module: fifo_bypass_cfg

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, meaning width of each data word.
REQ-002 The block SHALL have parameter DEPTH, default 3, meaning storage entries (legal range >=2, any integer, non-power-of-2 allowed).
REQ-003 The block SHALL have parameter AF_THRESH, default DEPTH-1, meaning occupancy at or above which almost-full asserts (1..DEPTH).
REQ-004 The block SHALL use derived widths ADDR_WIDTH=$clog2(DEPTH) and CNT_WIDTH=$clog2(DEPTH+1).
REQ-005 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-006 The ports SHALL be as follows:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous active-high reset
- i__bypass_en  in  1  runtime enable of empty-FIFO pass-through
- i__data_in_valid  in  1  input word valid
- i__data_in  in  DATA_WIDTH  input word
- o__data_in_ready  out  1  FIFO accepts input this cycle
- o__data_in_ready__next  out  1  value o__data_in_ready will take next cycle
- o__data_out_valid  out  1  output word valid
- o__data_out  out  DATA_WIDTH  output word
- i__data_out_ready  in  1  consumer accepts output
- i__clear_all  in  1  synchronous flush
- o__count  out  CNT_WIDTH  current stored occupancy
- o__almost_full  out  1  o__count >= AF_THRESH
- o__max_count  out  CNT_WIDTH  high-water mark of o__count since reset/clear
- oa__all_data  out  DATA_WIDTH x [0:DEPTH-1]  physical storage contents by index

Function
REQ-007 Storage SHALL be a circular buffer with wr_ptr, rd_ptr (ADDR_WIDTH) and count (0..DEPTH); pointers increment modulo DEPTH (DEPTH=3: 2 wraps to 0).
REQ-008 o__data_in_ready SHALL be (count<DEPTH) & ~i__clear_all & ~reset; no same-cycle push when full even if a pop occurs.
REQ-009 Bypass condition SHALL be count==0 & i__bypass_en & i__data_in_valid & ~reset & ~i__clear_all.
REQ-010 Under bypass condition: o__data_out_valid=1, o__data_out=i__data_in combinationally (zero latency); if i__data_out_ready=1 the word is consumed and NOT written; else it is written.
REQ-011 Otherwise: o__data_out_valid = (count!=0) & ~i__clear_all; o__data_out = mem[rd_ptr].
REQ-012 push = i__data_in_valid & o__data_in_ready & ~(bypass condition & i__data_out_ready); push writes mem[wr_ptr], advances wr_ptr.
REQ-013 pop = o__data_out_valid & i__data_out_ready & count!=0; pop advances rd_ptr; storage data not cleared on pop.
REQ-014 count_next = count + push - pop; simultaneous push and pop leaves count unchanged, both pointers advance.
REQ-015 o__data_in_ready__next SHALL equal (count_next<DEPTH), forced 0 while reset asserted; after clear cycle it is 1.
REQ-016 With i__bypass_en=0, latency from accepted input to o__data_out_valid on empty FIFO SHALL be 1 cycle; with bypass enabled, 0 cycles.
REQ-017 i__bypass_en MAY change any cycle; it affects only the current cycle's bypass decision, never stored data order.
REQ-018 o__almost_full and o__count SHALL be registered-state-derived (no combinational path from inputs).
REQ-019 o__max_count SHALL update to count_next when count_next > o__max_count; saturates at DEPTH.
REQ-020 i__clear_all SHALL take priority over push/pop: next edge sets count, wr_ptr, rd_ptr, o__max_count to 0; oa__all_data contents retained.
REQ-021 Output data order SHALL be strict FIFO across mixed bypass and stored words.

Reset
REQ-022 While reset=1 (asynchronously): count, pointers, o__max_count = 0; all oa__all_data entries = 0; o__data_out_valid=0, o__data_in_ready=0, o__almost_full=0, bypass suppressed.
REQ-023 Reset asserted mid-transfer SHALL discard all stored data; first cycle after deassert o__data_in_ready=1, o__count=0.

Verification (DATA_WIDTH=8, DEPTH=3, AF_THRESH=2)
REQ-024 Bypass: empty, bypass_en=1, in_valid=1 data 0x5A, out_ready=1 -> same cycle out_valid=1 data 0x5A; next cycle o__count=0.
REQ-025 No bypass: bypass_en=0, push 0x11 with out_ready=1 -> out_valid=0 that cycle; next cycle out_valid=1 data 0x11, count=1.
REQ-026 Fill/wrap: push 0x01,0x02,0x03 with out_ready=0 -> count=3, in_ready=0, almost_full=1, max_count=3; pop one, push 0x04 -> 0x04 stored in oa__all_data[0]; drain order 0x02,0x03,0x04.
REQ-027 Simultaneous: count=2, push and pop same cycle -> count stays 2, in_ready__next=1; at count=3 with pop, in_valid ignored.
REQ-028 Clear: count=2, assert i__clear_all with in_valid=1 -> in_ready=0, out_valid=0 that cycle; next cycle count=0, max_count=0, in_ready=1.
REQ-029 Async reset: count=2, assert reset between edges -> outputs reach reset values immediately; after release count=0, oa__all_data all 0x00.

Source files
------------

// File: rtl/fifo_bypass_cfg_if.sv
// Handshake/bus bundle for fifo_bypass_cfg: producer, consumer, flush and status signals.
// The slave modport is the FIFO; the master modport is whatever drives it.
interface fifo_bypass_cfg_if #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 3
);
  localparam int CNT_WIDTH = $clog2(DEPTH + 1);

  logic                  i__bypass_en;
  logic                  i__data_in_valid;
  logic [DATA_WIDTH-1:0] i__data_in;
  logic                  o__data_in_ready;
  logic                  o__data_in_ready__next;
  logic                  o__data_out_valid;
  logic [DATA_WIDTH-1:0] o__data_out;
  logic                  i__data_out_ready;
  logic                  i__clear_all;
  logic [CNT_WIDTH-1:0]  o__count;
  logic                  o__almost_full;
  logic [CNT_WIDTH-1:0]  o__max_count;
  logic [DATA_WIDTH-1:0] oa__all_data [0:DEPTH-1];

  modport slave (
    input  i__bypass_en, i__data_in_valid, i__data_in, i__data_out_ready, i__clear_all,
    output o__data_in_ready, o__data_in_ready__next, o__data_out_valid, o__data_out,
    output o__count, o__almost_full, o__max_count, oa__all_data
  );

  modport master (
    output i__bypass_en, i__data_in_valid, i__data_in, i__data_out_ready, i__clear_all,
    input  o__data_in_ready, o__data_in_ready__next, o__data_out_valid, o__data_out,
    input  o__count, o__almost_full, o__max_count, oa__all_data
  );
endinterface

// File: rtl/fifo_bypass_cfg.sv
// Circular-buffer FIFO with optional zero-latency pass-through when empty, synchronous
// flush, occupancy/high-water status. Valid/ready: a word moves when valid & ready at a rising edge.
module fifo_bypass_cfg #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 3,
  parameter int AF_THRESH  = DEPTH - 1
) (
  input  logic             clk,
  input  logic             reset,
  fifo_bypass_cfg_if.slave io
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int CNT_WIDTH  = $clog2(DEPTH + 1);
  localparam logic [CNT_WIDTH-1:0]  DEPTH_C = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0]  AF_C    = CNT_WIDTH'(AF_THRESH);
  localparam logic [ADDR_WIDTH-1:0] LAST_C  = ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [CNT_WIDTH-1:0]  max_q, max_d;

  logic in_ready, bypass, out_valid, push, pop;

  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    in_ready  = (count_q < DEPTH_C) & ~io.i__clear_all & ~reset;
    bypass    = (count_q == '0) & io.i__bypass_en & io.i__data_in_valid & ~reset & ~io.i__clear_all;
    out_valid = bypass | ((count_q != '0) & ~io.i__clear_all);
    // A bypassed word taken by the consumer never touches storage.
    push      = io.i__data_in_valid & in_ready & ~(bypass & io.i__data_out_ready);
    pop       = out_valid & io.i__data_out_ready & (count_q != '0);

    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
    max_d    = (count_d > max_q) ? count_d : max_q;
    if (io.i__clear_all) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      max_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      max_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      max_q    <= max_d;
      if (push) mem_q[wr_ptr_q] <= io.i__data_in;
    end
  end

  always_comb begin
    io.o__data_in_ready       = in_ready;
    io.o__data_in_ready__next = (count_d < DEPTH_C) & ~reset;
    io.o__data_out_valid      = out_valid;
    io.o__data_out            = bypass ? io.i__data_in : mem_q[rd_ptr_q];
    io.o__count               = count_q;
    io.o__almost_full         = (count_q >= AF_C);
    io.o__max_count           = max_q;
    for (int i = 0; i < DEPTH; i++) io.oa__all_data[i] = mem_q[i];
  end
endmodule

// File: tb/tb_fifo_bypass_cfg.sv
// Directed bench for fifo_bypass_cfg at DATA_WIDTH=8, DEPTH=3, AF_THRESH=2.
module tb_fifo_bypass_cfg;
  logic clk;
  logic reset;
  int   vec_cnt;
  int   err_cnt;
  logic [7:0] exp_q[$];
  logic [7:0] exp_w;

  fifo_bypass_cfg_if #(.DATA_WIDTH(8), .DEPTH(3)) bus ();

  fifo_bypass_cfg #(.DATA_WIDTH(8), .DEPTH(3), .AF_THRESH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus.slave)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver: apply inputs just after a falling edge, leave settle time before checks
  task automatic drive(input logic bp, input logic v, input logic [7:0] d,
                       input logic ordy, input logic clr);
    @(negedge clk);
    bus.i__bypass_en      = bp;
    bus.i__data_in_valid  = v;
    bus.i__data_in        = d;
    bus.i__data_out_ready = ordy;
    bus.i__clear_all      = clr;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    reset = 1'b1;
    bus.i__bypass_en = 1'b0; bus.i__data_in_valid = 1'b0; bus.i__data_in = 8'h00;
    bus.i__data_out_ready = 1'b0; bus.i__clear_all = 1'b0;
    #3;
    check("rst_count", bus.o__count, 0);
    check("rst_in_ready", bus.o__data_in_ready, 0);
    check("rst_in_ready_next", bus.o__data_in_ready__next, 0);
    check("rst_out_valid", bus.o__data_out_valid, 0);
    check("rst_af", bus.o__almost_full, 0);
    @(negedge clk); reset = 1'b0; #1;
    check("post_rst_in_ready", bus.o__data_in_ready, 1);

    // bypass, consumer ready: same-cycle delivery, nothing stored
    drive(1'b1, 1'b1, 8'h5A, 1'b1, 1'b0);
    check("byp_valid", bus.o__data_out_valid, 1);
    check("byp_data", bus.o__data_out, 8'h5A);
    idle();
    check("byp_count", bus.o__count, 0);
    check("byp_max", bus.o__max_count, 0);

    // no bypass: one cycle latency
    drive(1'b0, 1'b1, 8'h11, 1'b1, 1'b0);
    check("nobyp_valid0", bus.o__data_out_valid, 0);
    idle();
    check("nobyp_valid1", bus.o__data_out_valid, 1);
    check("nobyp_data", bus.o__data_out, 8'h11);
    check("nobyp_count", bus.o__count, 1);
    check("nobyp_af", bus.o__almost_full, 0);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    idle();
    check("nobyp_drained", bus.o__count, 0);

    // clear to home both pointers, then fill and wrap
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    idle();
    check("clr_max", bus.o__max_count, 0);
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
      exp_q.push_back(8'(i));
    end
    idle();
    check("fill_count", bus.o__count, 3);
    check("fill_in_ready", bus.o__data_in_ready, 0);
    check("fill_af", bus.o__almost_full, 1);
    check("fill_max", bus.o__max_count, 3);
    for (int i = 0; i < 3; i++) check($sformatf("fill_mem%0d", i), bus.oa__all_data[i], i + 1);
    // full with pop: the offered word is ignored
    drive(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0);
    check("full_pop_in_ready", bus.o__data_in_ready, 0);
    exp_w = exp_q.pop_front();
    check("full_pop_data", bus.o__data_out, exp_w);
    idle();
    check("full_pop_count", bus.o__count, 2);
    check("full_pop_mem0", bus.oa__all_data[0], 8'h01);
    drive(1'b0, 1'b1, 8'h04, 1'b0, 1'b0);
    exp_q.push_back(8'h04);
    idle();
    check("wrap_mem0", bus.oa__all_data[0], 8'h04);
    check("wrap_count", bus.o__count, 3);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      exp_w = exp_q.pop_front();
      check($sformatf("drain%0d", i), bus.o__data_out, exp_w);
      check($sformatf("drain_valid%0d", i), bus.o__data_out_valid, 1);
    end
    idle();
    check("drain_count", bus.o__count, 0);
    check("drain_valid_end", bus.o__data_out_valid, 0);

    // simultaneous push/pop at count 2 (rd/wr both at 1)
    drive(1'b0, 1'b1, 8'hA1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'hA2, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'hA3, 1'b1, 1'b0);
    check("sim_in_ready_next", bus.o__data_in_ready__next, 1);
    check("sim_data", bus.o__data_out, 8'hA1);
    idle();
    check("sim_count", bus.o__count, 2);
    check("sim_mem0", bus.oa__all_data[0], 8'hA3);
    check("sim_af", bus.o__almost_full, 1);

    // clear with input offered
    drive(1'b0, 1'b1, 8'hBB, 1'b0, 1'b1);
    check("clr_in_ready", bus.o__data_in_ready, 0);
    check("clr_out_valid", bus.o__data_out_valid, 0);
    check("clr_in_ready_next", bus.o__data_in_ready__next, 1);
    idle();
    check("clr_count", bus.o__count, 0);
    check("clr_max2", bus.o__max_count, 0);
    check("clr_in_ready_after", bus.o__data_in_ready, 1);
    check("clr_mem_kept0", bus.oa__all_data[0], 8'hA3);
    check("clr_mem_kept2", bus.oa__all_data[2], 8'hA2);

    // bypass offered but consumer stalled: word is stored, order preserved
    drive(1'b1, 1'b1, 8'hC7, 1'b0, 1'b0);
    check("bst_valid", bus.o__data_out_valid, 1);
    check("bst_data", bus.o__data_out, 8'hC7);
    idle();
    check("bst_count", bus.o__count, 1);
    drive(1'b1, 1'b1, 8'hC8, 1'b1, 1'b0);
    check("mix_data", bus.o__data_out, 8'hC7);
    idle();
    check("mix_next", bus.o__data_out, 8'hC8);
    check("mix_count", bus.o__count, 1);
    drive(1'b0, 1'b1, 8'hC9, 1'b0, 1'b0);
    idle();
    check("pre_rst_count", bus.o__count, 2);

    // asynchronous reset between edges
    @(negedge clk); #2;
    reset = 1'b1; #1;
    check("arst_count", bus.o__count, 0);
    check("arst_out_valid", bus.o__data_out_valid, 0);
    check("arst_in_ready", bus.o__data_in_ready, 0);
    check("arst_af", bus.o__almost_full, 0);
    check("arst_max", bus.o__max_count, 0);
    for (int i = 0; i < 3; i++) check($sformatf("arst_mem%0d", i), bus.oa__all_data[i], 0);
    @(negedge clk); reset = 1'b0; #1;
    check("arst_release_in_ready", bus.o__data_in_ready, 1);
    check("arst_release_count", bus.o__count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
